systolic_tile_scheduler: RTL



---
 rtl/systolic_sched_pkg.sv | 18 +
 rtl/systolic_acc_bank.sv | 33 +++
 rtl/systolic_tile_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/systolic_sched_pkg.sv
// Shared types for the systolic tile scheduler: FSM states, default-size tile
// containers and the width of the tile counter.
package systolic_sched_pkg;

    localparam int SCHED_N    = 8;
    localparam int TILE_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    typedef logic [SCHED_N-1:0][SCHED_N-1:0][7:0]  tile8_t;
    typedef logic [SCHED_N-1:0][SCHED_N-1:0][31:0] acc32_t;

endpackage

// File: rtl/systolic_acc_bank.sv
// N x N 32-bit accumulator bank: overwrite, element-wise wrap-around add, or clear.
// Latency: 1 cycle from i_load/i_add to o_q. No backpressure.
// Clear has priority, then load, then add.
module systolic_acc_bank #(
    parameter int N = 8
) (
    input  logic                      i_clk,
    input  logic                      i_clr,
    input  logic                      i_load,
    input  logic                      i_add,
    input  logic [N-1:0][N-1:0][31:0] i_d,
    output logic [N-1:0][N-1:0][31:0] o_q
);

    logic [N-1:0][N-1:0][31:0] acc_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            acc_q <= '0;
        end else if (i_load) begin
            acc_q <= i_d;
        end else if (i_add) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= acc_q[i][j] + i_d[i][j];
                end
            end
        end
    end

    assign o_q = acc_q;

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Shares one systolic array over a stream of A/B tile pairs, summing products along K.
// Latency: issue 1 cycle after accept; result visible 1 cycle after the array strobe.
// Backpressure: one tile in flight; o_tileReady only in IDLE; DONE holds until i_resReady.
// Optional watchdog on the WAIT state: SYSTOLIC_SCHED_WATCHDOG_EN.
module systolic_tile_scheduler
    import systolic_sched_pkg::*;
#(
    parameter int N              = 8,
    parameter int TIMEOUT_CYCLES = 4 * N + 8
) (
    input  logic                      i_clk,
    input  logic                      i_srst,
    input  logic                      i_tileValid,
    output logic                      o_tileReady,
    input  logic [N-1:0][N-1:0][7:0]  i_tileA,
    input  logic [N-1:0][N-1:0][7:0]  i_tileB,
    input  logic                      i_tileLast,
    output logic [N-1:0][N-1:0][7:0]  o_saA,
    output logic [N-1:0][N-1:0][7:0]  o_saB,
    output logic                      o_saValidInput,
    input  logic [N-1:0][N-1:0][31:0] i_saC,
    input  logic                      i_saValidResult,
    output logic                      o_resValid,
    input  logic                      i_resReady,
    output logic [N-1:0][N-1:0][31:0] o_res,
    output logic [TILE_CNT_W-1:0]     o_resTiles,
    output logic                      o_resErr,
    output logic                      o_busy
);

    sched_state_e                state_q, state_nxt;
    logic [N-1:0][N-1:0][7:0]    op_a_q, op_b_q;
    logic                        last_q;
    logic                        acc_vld_q;
    logic [TILE_CNT_W-1:0]       cnt_q;
    logic                        tile_rdy_q, sa_vld_q, res_vld_q, err_q, busy_q;
    logic                        tile_take, result_take, res_take, wd_timeout;

    always_comb begin
        state_nxt   = state_q;
        tile_take   = 1'b0;
        result_take = 1'b0;
        res_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_tileValid && tile_rdy_q) begin
                    tile_take = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (i_saValidResult) begin
                    result_take = 1'b1;
                    state_nxt   = last_q ? DONE : IDLE;
                end else if (wd_timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_resReady) begin
                    res_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so every output is a flop.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            last_q     <= 1'b0;
            acc_vld_q  <= 1'b0;
            cnt_q      <= '0;
            tile_rdy_q <= 1'b1;
            sa_vld_q   <= 1'b0;
            res_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            tile_rdy_q <= (state_nxt == IDLE);
            sa_vld_q   <= (state_nxt == ISSUE);
            res_vld_q  <= (state_nxt == DONE);
            busy_q     <= (state_nxt != IDLE) || result_take || (acc_vld_q && !res_take);
            if (tile_take) begin
                op_a_q <= i_tileA;
                op_b_q <= i_tileB;
                last_q <= i_tileLast;
            end
            if (result_take) begin
                acc_vld_q <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (wd_timeout) begin
                err_q <= 1'b1;
            end
            if (res_take) begin
                acc_vld_q <= 1'b0;
                cnt_q     <= '0;
                err_q     <= 1'b0;
            end
        end
    end

`ifdef SYSTOLIC_SCHED_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_srst || state_q != WAIT) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign wd_timeout = (state_q == WAIT) && !i_saValidResult && (wd_cnt_q == WD_LAST);
`else
    assign wd_timeout = 1'b0;
`endif

    systolic_acc_bank #(
        .N (N)
    ) u_acc_bank (
        .i_clk  (i_clk),
        .i_clr  (i_srst),
        .i_load (result_take && !acc_vld_q),
        .i_add  (result_take && acc_vld_q),
        .i_d    (i_saC),
        .o_q    (o_res)
    );

    assign o_tileReady    = tile_rdy_q;
    assign o_saA          = op_a_q;
    assign o_saB          = op_b_q;
    assign o_saValidInput = sa_vld_q;
    assign o_resValid     = res_vld_q;
    assign o_resTiles     = cnt_q;
    assign o_resErr       = err_q;
    assign o_busy         = busy_q;

endmodule
